// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: input-rate comb chain, zero-stuffing by R, clock-rate
// integrators, and a gain-normalised, compensated and saturated output stage.
module cic_interpolator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned R_MAX = 64,
    parameter int unsigned N     = 3,
    parameter int unsigned M     = 1,
    parameter int unsigned R     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [15:0]      cic_compensation_factor,
    input  logic signed [WIDTH-1:0] inData,
    input  logic                    in_valid,
    output logic                    interp_en,
    output logic signed [WIDTH-1:0] outData,
    output logic                    out_valid,
    output logic                    underflow,
    output logic                    sat_pulse
);
    localparam int unsigned ACC_W  = WIDTH + N * $clog2(R_MAX * M);
    localparam int unsigned PH_W   = (R > 2) ? $clog2(R) : 1;
    localparam int unsigned COMP_W = 16;
    localparam int unsigned PROD_W = ACC_W + COMP_W;
    localparam int unsigned QW     = PROD_W + 1;

    // Net DC gain of the comb/upsample/integrator path per output sample.
    function automatic longint unsigned cic_gain();
        longint unsigned g;
        g = 64'd1;
        for (int i = 0; i < int'(N); i++) begin
            g = g * 64'(R * M);
        end
        return g / 64'(R);
    endfunction

    localparam longint unsigned G = cic_gain();
    localparam logic signed [QW-1:0] DIV    = QW'(G << 14);
    localparam logic signed [QW-1:0] SAT_HI = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0] SAT_LO = {{(QW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [PH_W-1:0]         phase;
    logic signed [ACC_W-1:0] comb_dly [N][M];
    logic signed [ACC_W-1:0] comb_stage [N+1];
    logic signed [ACC_W-1:0] comb_reg;
    logic signed [ACC_W-1:0] inj_reg;
    logic signed [ACC_W-1:0] integ [N];
    logic signed [PROD_W-1:0] prod;
    logic signed [QW-1:0]    quot;
    logic                    sat_hi;
    logic                    sat_lo;

    assign interp_en = enable && (phase == '0);

    // Comb chain, evaluated combinationally on the sample being taken.
    always_comb begin
        comb_stage[0] = in_valid ? ACC_W'(inData) : '0;
        for (int i = 0; i < int'(N); i++) begin
            comb_stage[i+1] = comb_stage[i] - comb_dly[i][M-1];
        end
    end

    // Compensation, normalisation (truncating toward zero) and clip detection.
    always_comb begin
        prod   = PROD_W'(integ[N-1]) * PROD_W'(cic_compensation_factor);
        quot   = QW'(prod) / DIV;
        sat_hi = quot > SAT_HI;
        sat_lo = quot < SAT_LO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            comb_reg  <= '0;
            inj_reg   <= '0;
            outData   <= '0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
            sat_pulse <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                integ[i] <= '0;
                for (int j = 0; j < int'(M); j++) begin
                    comb_dly[i][j] <= '0;
                end
            end
        end else if (enable) begin
            if (phase == PH_W'(R - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end

            if (interp_en) begin
                comb_reg <= comb_stage[N];
                if (!in_valid) begin
                    underflow <= 1'b1;
                end
                for (int i = 0; i < int'(N); i++) begin
                    for (int j = 1; j < int'(M); j++) begin
                        comb_dly[i][j] <= comb_dly[i][j-1];
                    end
                    comb_dly[i][0] <= comb_stage[i];
                end
            end

            // Zero-stuffing: the comb result enters the integrators once per R cycles.
            inj_reg  <= (phase == PH_W'(1)) ? comb_reg : '0;
            integ[0] <= integ[0] + inj_reg;
            for (int k = 1; k < int'(N); k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end

            if (sat_hi) begin
                outData <= SAT_HI[WIDTH-1:0];
            end else if (sat_lo) begin
                outData <= SAT_LO[WIDTH-1:0];
            end else begin
                outData <= quot[WIDTH-1:0];
            end
            sat_pulse <= sat_hi || sat_lo;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            sat_pulse <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator (N=3, M=1, R=4): convolution reference model with a
// per-cycle scoreboard, a DC/compensation vector table and hand-written sequences.
module tb_cic_interpolator;
    localparam int unsigned WIDTH = 16;
    localparam int          RR    = 4;
    localparam int          HLEN  = 10;
    localparam int          LAT   = 5;
    localparam longint      GDIV  = 64'sd16 * 64'sd16384;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic signed [15:0]      comp;
    logic signed [WIDTH-1:0] inData;
    logic                    in_valid;
    logic                    interp_en;
    logic signed [WIDTH-1:0] outData;
    logic                    out_valid;
    logic                    underflow;
    logic                    sat_pulse;

    always #5 clk = ~clk;

    cic_interpolator #(.WIDTH(WIDTH), .R_MAX(64), .N(3), .M(1), .R(RR)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .cic_compensation_factor (comp),
        .inData                  (inData),
        .in_valid                (in_valid),
        .interp_en               (interp_en),
        .outData                 (outData),
        .out_valid               (out_valid),
        .underflow               (underflow),
        .sat_pulse               (sat_pulse)
    );

    typedef struct {
        logic signed [15:0] out;
        logic               valid;
        logic               uf;
        logic               sat;
    } exp_t;

    typedef struct {
        int din;
        int cmp;
        int exp_out;
        bit exp_sat;
    } vec_t;

    exp_t               sb_q[$];
    longint             xz[$];
    int                 h [HLEN];
    int                 m_e;
    bit                 m_uf;
    logic signed [15:0] m_out;
    int                 checks;
    int                 failures;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Filter output at enabled edge e: zero-stuffed samples convolved with the kernel.
    function automatic longint model_y(input int e);
        longint y;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
            if (e - LAT - j >= 0) y += longint'(h[j]) * xz[e - LAT - j];
        end
        return y;
    endfunction

    // One clock: drive, check interp_en, predict, clock, compare against the scoreboard.
    task automatic cycle(input bit en, input int din, input bit vld, input bit rst);
        longint p;
        bit     strobe;
        bit     sat;
        exp_t   e;
        enable   = en;
        reset    = rst;
        inData   = WIDTH'(din);
        in_valid = vld;
        #1;
        if (!rst) check("interp_en", interp_en, en && (m_e % RR == 0));
        if (rst) begin
            xz.delete();
            m_e   = 0;
            m_uf  = 0;
            m_out = '0;
            sb_q.push_back('{16'sd0, 1'b0, 1'b0, 1'b0});
        end else if (en) begin
            strobe = (m_e % RR == 0);
            xz.push_back((strobe && vld) ? longint'(din) : 64'sd0);
            if (strobe && !vld) m_uf = 1;
            p   = (model_y(m_e) * longint'(comp)) / GDIV;
            sat = 0;
            if (p > 32767) begin
                p = 32767;
                sat = 1;
            end else if (p < -32768) begin
                p = -32768;
                sat = 1;
            end
            m_out = 16'(p);
            sb_q.push_back('{m_out, 1'b1, m_uf, sat});
            m_e++;
        end else begin
            sb_q.push_back('{m_out, 1'b0, m_uf, 1'b0});
        end
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb_q.pop_front();
            check("outData", outData, e.out);
            check("out_valid", out_valid, e.valid);
            check("underflow", underflow, e.uf);
            if (e.valid) check("sat_pulse", sat_pulse, e.sat);
        end
    endtask

    vec_t vecs [9];
    int   imp_exp [HLEN];

    initial begin
        checks   = 0;
        failures = 0;
        m_e      = 0;
        m_uf     = 0;
        m_out    = '0;
        comp     = 16'sd16384;
        enable   = 1'b0;
        reset    = 1'b1;
        inData   = '0;
        in_valid = 1'b0;

        // Kernel: three length-4 boxcars convolved, counted directly.
        for (int j = 0; j < HLEN; j++) h[j] = 0;
        for (int a = 0; a < RR; a++)
            for (int b = 0; b < RR; b++)
                for (int c = 0; c < RR; c++) h[a+b+c]++;
        imp_exp = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

        vecs[0] = '{1000,   16384,  1000,   1'b0};
        vecs[1] = '{20000,  24576,  30000,  1'b0};
        vecs[2] = '{30000,  24576,  32767,  1'b1};
        vecs[3] = '{-30000, 24576,  -32768, 1'b1};
        vecs[4] = '{20000,  8192,   10000,  1'b0};
        vecs[5] = '{-1000,  16385,  -1000,  1'b0};
        vecs[6] = '{1000,   -16384, -1000,  1'b0};
        vecs[7] = '{32767,  16384,  32767,  1'b0};
        vecs[8] = '{-32768, 16384,  -32768, 1'b0};

        // DC, compensation, truncation and saturation vectors.
        for (int v = 0; v < 9; v++) begin
            comp = 16'(vecs[v].cmp);
            cycle(1'b1, 0, 1'b0, 1'b1);
            for (int i = 0; i < 30; i++) cycle(1'b1, vecs[v].din, 1'b1, 1'b0);
            check("tbl_out", outData, vecs[v].exp_out);
            check("tbl_sat", sat_pulse, vecs[v].exp_sat);
            check("tbl_uf", underflow, 0);
        end

        // Impulse response.
        comp = 16'sd16384;
        cycle(1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, (i == 0) ? 16 : 0, 1'b1, 1'b0);
            check("impulse", outData,
                  (i >= LAT && i < LAT + HLEN) ? imp_exp[i - LAT] : 0);
        end

        // Underflow: dropped valid off-strobe is ignored, on a strobe it sticks.
        cycle(1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 36; i++)
            cycle(1'b1, 1000, !(i == 13 || i == 16), 1'b0);
        check("uf_sticky", underflow, 1);
        cycle(1'b1, 1000, 1'b1, 1'b1);
        check("uf_cleared", underflow, 0);

        // Enable gap of 7 cycles in a changing stream.
        for (int i = 0; i < 44; i++)
            cycle(!(i >= 10 && i < 17), 300 * (i % 5) - 600, 1'b1, 1'b0);

        // Reset mid-stream at phase 2, then re-converge.
        cycle(1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1000, 1'b1, 1'b0);
        check("pre_reset_phase", m_e % RR, 2);
        cycle(1'b1, 1000, 1'b1, 1'b1);
        check("rst_out", outData, 0);
        check("rst_valid", out_valid, 0);
        for (int i = 0; i < 30; i++) cycle(1'b1, 1000, 1'b1, 1'b0);
        check("reconverge", outData, 1000);

        // Reset dominates a low enable.
        cycle(1'b0, 1000, 1'b1, 1'b1);
        check("rst_dom", outData, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
